pll_reset_controller: RTL and testbench

Supervises the system PLL from the free-running 50 MHz board reference clock. It drives the PLL asynchronous reset and watches the PLL locked output. It holds the system in reset until lock has been stable for a programmable time, and re-runs the PLL reset sequence on loss of lock, lock timeout or software request. It sits at the top level between the board clock input, the PLL and the reset tree of the CPU/SDRAM domains.

---
 rtl/pll_reset_pkg.sv | 20 ++
 rtl/bit_sync.sv | 21 ++
 rtl/pll_reset_controller.sv | 113 +++++++++++
 tb/tb_pll_reset_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and sizing helpers for the PLL reset supervisor.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Width of a counter that must reach the largest of three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Generic two-flop synchroniser for single-bit CDC; resets to 0.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_controller.sv
// Sequences the PLL reset, qualifies lock and gates the system reset.
// Retries the sequence on lock loss, lock timeout or software request.
module pll_reset_controller
  import pll_reset_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       force_reset,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] fault_count,
  output logic [1:0] state
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t           state_r, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             fault_evt;
  logic             locked_s;
  logic             pll_rst_d, sys_rst_n_d, ready_d;

  bit_sync u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // A forced restart while already in PLL_RST must still restart the count.
  assign cnt_clr = force_reset || (state_d != state_r);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= PLL_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      ready       <= 1'b0;
      fault_count <= 8'd0;
    end else begin
      state_r     <= state_d;
      pll_rst     <= pll_rst_d;
      sys_rst_n   <= sys_rst_n_d;
      ready       <= ready_d;
      if (cnt_clr)
        cnt <= '0;
      else if (state_r != RUN)
        cnt <= cnt + 1'b1;
      if (fault_evt)
        fault_count <= sat_inc(fault_count);
    end
  end

  always_comb begin
    state_d   = state_r;
    fault_evt = 1'b0;
    if (force_reset) begin
      state_d = PLL_RST;
    end else begin
      case (state_r)
        PLL_RST: begin
          if (cnt == PR_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt == TO_LAST) begin
            state_d   = PLL_RST;
            fault_evt = 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s)
            state_d = WAIT_LOCK;
          else if (cnt == ST_LAST)
            state_d = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_d   = PLL_RST;
            fault_evt = 1'b1;
          end
        end
        default: state_d = PLL_RST;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    pll_rst_d   = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  assign state = state_r;

endmodule

// File: tb/tb_pll_reset_controller.sv
// Scoreboard bench for pll_reset_controller: a cycle model predicts every
// registered output, plus directed checks on pulse widths and fault counts.
module tb_pll_reset_controller;

  localparam int PR = 4;
  localparam int ST = 8;
  localparam int TO = 32;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       force_reset = 1'b0;
  logic       pll_rst, sys_rst_n, ready;
  logic [7:0] fault_count;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  int prst_hi = 0;

  int m_st, m_dwell, m_fault;
  bit m_s1, m_s2;
  logic [12:0] sb[$];

  pll_reset_controller #(
    .PLL_RST_CYCLES      (PR),
    .LOCK_STABLE_CYCLES  (ST),
    .LOCK_TIMEOUT_CYCLES (TO)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .locked      (locked),
    .force_reset (force_reset),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault_count (fault_count),
    .state       (state)
  );

  always #5 refclk = ~refclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_dwell = 0;
    m_fault = 0;
    m_s1 = 1'b0;
    m_s2 = 1'b0;
    sb.delete();
  endtask

  function automatic logic [12:0] model_out();
    logic [1:0] s;
    logic [7:0] f;
    s = m_st[1:0];
    f = m_fault[7:0];
    return {s, (m_st == 0), (m_st == 3), (m_st == 3), f};
  endfunction

  task automatic bump_fault();
    if (m_fault < 255) m_fault++;
  endtask

  task automatic model_step(input bit lk, input bit fr);
    bit ls;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = lk;
    if (fr) begin
      m_st = 0;
      m_dwell = 0;
    end else begin
      case (m_st)
        0: if (m_dwell == PR - 1) begin m_st = 1; m_dwell = 0; end
           else m_dwell++;
        1: if (ls) begin m_st = 2; m_dwell = 0; end
           else if (m_dwell == TO - 1) begin m_st = 0; m_dwell = 0; bump_fault(); end
           else m_dwell++;
        2: if (!ls) begin m_st = 1; m_dwell = 0; end
           else if (m_dwell == ST - 1) begin m_st = 3; m_dwell = 0; end
           else m_dwell++;
        default: if (!ls) begin m_st = 0; m_dwell = 0; bump_fault(); end
      endcase
    end
  endtask

  // Drive one cycle of inputs at the falling edge, predict, compare after the rise.
  task automatic cycle(input bit lk, input bit fr);
    logic [12:0] exp, got;
    locked = lk;
    force_reset = fr;
    model_step(lk, fr);
    sb.push_back(model_out());
    @(posedge refclk);
    @(negedge refclk);
    ncyc++;
    got = {state, pll_rst, sys_rst_n, ready, fault_count};
    exp = sb.pop_front();
    check_val("sb_outputs", got, exp);
    if (pll_rst) prst_hi++;
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_state"}, state, 0);
    check_val({tag, "_pll_rst"}, pll_rst, 1);
    check_val({tag, "_sys_rst_n"}, sys_rst_n, 0);
    check_val({tag, "_ready"}, ready, 0);
    check_val({tag, "_fault"}, fault_count, 0);
  endtask

  initial begin
    bit hit;
    model_reset();
    repeat (3) @(negedge refclk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    prst_hi = int'(pll_rst);

    // bring-up
    repeat (10) cycle(1'b0, 1'b0);
    check_val("bringup_prst_width", prst_hi, PR);
    repeat (14) cycle(1'b1, 1'b0);
    check_val("bringup_ready", ready, 1);
    check_val("bringup_sys_rst_n", sys_rst_n, 1);
    check_val("bringup_fault", fault_count, 0);

    // lock loss in RUN
    prst_hi = 0;
    repeat (3) cycle(1'b0, 1'b0);
    check_val("loss_state", state, 0);
    check_val("loss_fault", fault_count, 1);
    check_val("loss_sys_rst_n", sys_rst_n, 0);
    repeat (9) cycle(1'b0, 1'b0);
    check_val("loss_prst_width", prst_hi, PR);
    repeat (14) cycle(1'b1, 1'b0);
    check_val("relock_ready", ready, 1);

    // force_reset in RUN then in STABLE
    prst_hi = 0;
    cycle(1'b1, 1'b1);
    repeat (11) cycle(1'b1, 1'b0);
    check_val("force_run_prst_width", prst_hi, PR);
    check_val("force_in_stable", state, 2);
    prst_hi = 0;
    cycle(1'b1, 1'b1);
    repeat (7) cycle(1'b1, 1'b0);
    check_val("force_stable_prst_width", prst_hi, PR);
    check_val("force_fault", fault_count, 1);
    repeat (14) cycle(1'b1, 1'b0);
    check_val("force_back_run", ready, 1);

    // unstable lock: glitch low during STABLE
    cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b0);
    repeat (5) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0);
    check_val("unstable_not_ready", ready, 0);
    repeat (10) cycle(1'b1, 1'b0);
    check_val("unstable_ready", ready, 1);
    check_val("unstable_fault", fault_count, 1);

    // force coincident with lock loss in RUN
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check_val("coinc_loss_state", state, 0);
    check_val("coinc_loss_fault", fault_count, 1);

    // force coincident with lock timeout
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (m_st == 1 && m_dwell == TO - 1) begin
        cycle(1'b0, 1'b1);
        hit = 1'b1;
        break;
      end
      cycle(1'b0, 1'b0);
    end
    check_val("coinc_to_reached", hit, 1);
    check_val("coinc_to_fault", fault_count, 1);

    // repeated timeouts
    prst_hi = 0;
    repeat (3 * (PR + TO)) cycle(1'b0, 1'b0);
    check_val("timeout_fault", fault_count, 4);
    check_val("timeout_prst_cycles", prst_hi, 3 * PR);
    check_val("timeout_sys_rst_n", sys_rst_n, 0);

    // saturation
    repeat (300 * (PR + TO)) cycle(1'b0, 1'b0);
    check_val("sat_fault", fault_count, 255);

    // asynchronous reset mid-STABLE
    for (int i = 0; i < 80 && state != 2'd2; i++) cycle(1'b1, 1'b0);
    check_val("reach_stable", state, 2);
    repeat (3) cycle(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("async");
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (25) cycle(1'b1, 1'b0);
    check_val("rerun_ready", ready, 1);
    check_val("rerun_fault", fault_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
